serial_pattern_tx: RTL

Serial bit-pattern transmitter: the sending end of the single-bit `x` stream that our sequence-detecting FSMs consume. It accepts a parallel pattern plus a length and repeat count, then shifts the bits out MSB-first, one per clock, with fixed idle gaps between repetitions. It sits upstream of any detector in the lab top level and replaces hand-toggled switch input with repeatable, cycle-exact stimulus.

---
 rtl/serial_pattern_tx_if.sv | 28 ++
 rtl/serial_pattern_tx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - request/serial-output bundle for serial_pattern_tx
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) ();
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [3:0]       reps;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             frame_start;
  logic             done;

  // requester side: issues start/abort and the pattern description
  modport master (
    output start, pattern, len, reps, abort,
    input  x, x_valid, busy, frame_start, done
  );

  // transmitter side
  modport slave (
    input  start, pattern, len, reps, abort,
    output x, x_valid, busy, frame_start, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - MSB-first serial pattern transmitter with repeats and idle gaps
module serial_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   LEN_W      = 4,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  serial_pattern_tx_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  // gap counter counts down from GAP_CYCLES-1, so it only needs to hold that value
  localparam int               GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]    GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);

  state_t           state;
  logic [LEN_W-1:0] idx;
  logic [GW-1:0]    gap_cnt;
  logic [3:0]       rep_cnt;   // repetitions still to send after the current one
  logic [WIDTH-1:0] pat;
  logic [LEN_W-1:0] len_r;

  logic [LEN_W-1:0] eff_len;
  logic [3:0]       eff_reps;

  // clamp the request: overlong lengths send the whole register, zero reps means one
  assign eff_len  = (bus.len > WIDTH_L) ? WIDTH_L : bus.len;
  assign eff_reps = (bus.reps == 4'd0) ? 4'd1 : bus.reps;

  // bit select through a shift so the index may be wider than log2(WIDTH)
  function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
    logic [WIDTH-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  // control FSM; outputs are registered alongside the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      idx             <= '0;
      gap_cnt         <= '0;
      rep_cnt         <= '0;
      pat             <= '0;
      len_r           <= '0;
      bus.x           <= IDLE_BIT;
      bus.x_valid     <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.frame_start <= 1'b0;
      bus.done        <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          bus.x       <= IDLE_BIT;
          bus.x_valid <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= S_IDLE;
          if (bus.start) begin
            pat   <= bus.pattern;
            len_r <= eff_len;
            if (eff_len == '0) begin
              state    <= S_DONE;
              bus.done <= 1'b1;
            end else begin
              state           <= S_SHIFT;
              idx             <= eff_len - 1'b1;
              rep_cnt         <= eff_reps - 4'd1;
              bus.x           <= bit_at(bus.pattern, eff_len - 1'b1);
              bus.x_valid     <= 1'b1;
              bus.busy        <= 1'b1;
              bus.frame_start <= 1'b1;
            end
          end
        end

        S_SHIFT, S_GAP: begin
          if (bus.abort) begin
            state       <= S_IDLE;
            idx         <= '0;
            gap_cnt     <= '0;
            rep_cnt     <= '0;
            bus.x       <= IDLE_BIT;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
          end else if (state == S_SHIFT && idx != '0) begin
            idx   <= idx - 1'b1;
            bus.x <= bit_at(pat, idx - 1'b1);
          end else if (state == S_SHIFT && rep_cnt == 4'd0) begin
            state       <= S_DONE;
            bus.done    <= 1'b1;
            bus.x       <= IDLE_BIT;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
          end else if (state == S_SHIFT && GAP_CYCLES > 0) begin
            state       <= S_GAP;
            rep_cnt     <= rep_cnt - 4'd1;
            gap_cnt     <= GAP_LAST;
            bus.x       <= IDLE_BIT;
            bus.x_valid <= 1'b0;
          end else if (state == S_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            // start of the next repetition, either straight from SHIFT or after the gap
            if (state == S_SHIFT) rep_cnt <= rep_cnt - 4'd1;
            state           <= S_SHIFT;
            idx             <= len_r - 1'b1;
            bus.x           <= bit_at(pat, len_r - 1'b1);
            bus.x_valid     <= 1'b1;
            bus.frame_start <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          bus.x       <= IDLE_BIT;
          bus.x_valid <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
